// File: rtl/fir_chan_sched.sv
// fir_chan_sched
//
// Round-robin scheduler that time-shares one FIR datapath among NUM_CH
// sample sources. A channel holds the grant for at most BURST samples.
// Before the FIR is handed to a different channel (or to any channel after
// reset or a stall abort) FLUSH_LEN zero samples are pushed through, so tap
// histories never mix. Every accepted sample carries its channel through a
// FIR_LAT-deep tag pipeline, so each FIR result leaves tagged with the
// channel it came from.
//
// Optional feature: define FIR_SCHED_TIMEOUT_EN to enable the stall
// watchdog. It counts consecutive cycles with fir_tvalid=1 and
// fir_tready=0. When the count reaches TIMEOUT it sets err (sticky until
// reset), drops back to IDLE, forgets the last channel and advances the
// round-robin pointer. Without the macro there is no counter and err is
// tied to 0.
//
// Ports
//   clk, reset       clock; asynchronous active-high reset
//   req_valid        per-channel sample valid            [NUM_CH]
//   req_data         per-channel signed 6-bit sample     [6*NUM_CH], ch i at [6i+5:6i]
//   req_ready        per-channel accept                  [NUM_CH]
//   fir_tdata        sample to FIR                       [6]
//   fir_tvalid       sample valid to FIR
//   fir_tready       FIR accept
//   fir_result       signed FIR output                   [8]
//   out_data         tagged result                       [8]
//   out_ch           channel of out_data                 [2]
//   out_valid        one-cycle pulse per result
//   busy             scheduler not idle (registered)
//   err              sticky stall error
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no grant; choose next requester from rr_ptr
// S_FLUSH | drive FLUSH_LEN zero samples into the FIR, sources held off
// S_GRANT | granted channel streams into the FIR, up to BURST samples

module fir_chan_sched #(
    parameter int NUM_CH    = 2,
    parameter int BURST     = 16,
    parameter int FLUSH_LEN = 8,
    parameter int FIR_LAT   = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     req_valid,
    input  logic [6*NUM_CH-1:0]   req_data,
    output logic [NUM_CH-1:0]     req_ready,
    output logic [5:0]            fir_tdata,
    output logic                  fir_tvalid,
    input  logic                  fir_tready,
    input  logic [7:0]            fir_result,
    output logic [7:0]            out_data,
    output logic [1:0]            out_ch,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_GRANT = 2'd2
    } state_t;

    localparam int CNT_W = 5;

    state_t             state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [1:0]         last_ch_q, last_ch_d;
    logic               last_valid_q, last_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               grant_valid;
    logic [5:0]         grant_data;
    logic               sel_found;
    logic [1:0]         sel_ch;
    logic [1:0]         next_ptr;
    logic               accept;
    logic               timeout;

    logic [FIR_LAT-1:0] tag_v;
    logic [1:0]         tag_ch [FIR_LAT];

    // Request and data of the currently granted channel.
    always_comb begin
        grant_valid = 1'b0;
        grant_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_q == 2'(i)) begin
                grant_valid = req_valid[i];
                grant_data  = req_data[6*i +: 6];
            end
        end
    end

    // First requester at or after rr_ptr, wrapping. The outer loop walks the
    // search order; the inner loop maps rr_ptr+k back into 0..NUM_CH-1.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!sel_found && req_valid[i] &&
                    ((int'(rr_ptr_q) + k == i) || (int'(rr_ptr_q) + k == i + NUM_CH))) begin
                    sel_found = 1'b1;
                    sel_ch    = 2'(i);
                end
            end
        end
    end

    assign next_ptr = (grant_q == 2'(NUM_CH - 1)) ? 2'd0 : grant_q + 2'd1;
    assign accept   = (state_q == S_GRANT) && grant_valid && fir_tready;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        last_ch_d    = last_ch_q;
        last_valid_d = last_valid_q;
        cnt_d        = cnt_q;
        fir_tvalid   = 1'b0;
        fir_tdata    = '0;
        req_ready    = '0;

        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    grant_d = sel_ch;
                    if (last_valid_q && (sel_ch == last_ch_q)) begin
                        state_d = S_GRANT;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_FLUSH;
                        cnt_d   = CNT_W'(FLUSH_LEN);
                    end
                end
            end

            S_FLUSH: begin
                fir_tvalid = 1'b1;
                if (fir_tready) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d      = S_GRANT;
                        cnt_d        = '0;
                        last_ch_d    = grant_q;
                        last_valid_d = 1'b1;
                    end
                end
            end

            S_GRANT: begin
                fir_tvalid = grant_valid;
                fir_tdata  = grant_data;
                for (int i = 0; i < NUM_CH; i++) begin
                    req_ready[i] = (grant_q == 2'(i)) && fir_tready;
                end
                if (!grant_valid) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = next_ptr;
                end else if (fir_tready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(BURST - 1)) begin
                        state_d  = S_IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A stalled FIR abandons the current grant; the flush history is no
        // longer trusted, so the next grant always flushes.
        if (timeout) begin
            state_d      = S_IDLE;
            last_valid_d = 1'b0;
            rr_ptr_d     = next_ptr;
            cnt_d        = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            last_ch_q    <= '0;
            last_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            last_ch_q    <= last_ch_d;
            last_valid_q <= last_valid_d;
            cnt_q        <= cnt_d;
        end
    end

`ifdef FIR_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] stall_q;
    logic            stall;

    assign stall   = fir_tvalid && !fir_tready;
    assign timeout = stall && (stall_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (!stall || timeout) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (timeout) begin
            err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // Tag pipeline: flush transfers and idle cycles load an invalid tag, so
    // only real samples produce an out_valid pulse FIR_LAT+1 cycles later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_v <= '0;
            for (int i = 0; i < FIR_LAT; i++) begin
                tag_ch[i] <= '0;
            end
        end else begin
            tag_v[0]  <= accept;
            tag_ch[0] <= grant_q;
            for (int i = 1; i < FIR_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_ch[i] <= tag_ch[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            busy      <= 1'b0;
        end else begin
            out_valid <= tag_v[FIR_LAT-1];
            if (tag_v[FIR_LAT-1]) begin
                out_data <= fir_result;
                out_ch   <= tag_ch[FIR_LAT-1];
            end
            busy <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_fir_chan_sched.sv
`timescale 1ns/1ps
module tb_fir_chan_sched;

    localparam int NUM_CH    = 2;
    localparam int BURST     = 16;
    localparam int FLUSH_LEN = 8;
    localparam int FIR_LAT   = 4;
    localparam int TIMEOUT   = 64;

    typedef struct packed {
        logic [1:0]  ch;
        logic [7:0]  data;
        logic [31:0] cyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset;
    logic [NUM_CH-1:0]   req_valid;
    logic [6*NUM_CH-1:0] req_data;
    logic [NUM_CH-1:0]   req_ready;
    logic [5:0]          fir_tdata;
    logic                fir_tvalid;
    logic                fir_tready;
    logic [7:0]          fir_result;
    logic [7:0]          out_data;
    logic [1:0]          out_ch;
    logic                out_valid;
    logic                busy;
    logic                err;

    fir_chan_sched #(
        .NUM_CH    (NUM_CH),
        .BURST     (BURST),
        .FLUSH_LEN (FLUSH_LEN),
        .FIR_LAT   (FIR_LAT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fir_tdata  (fir_tdata),
        .fir_tvalid (fir_tvalid),
        .fir_tready (fir_tready),
        .fir_result (fir_result),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_valid  (out_valid),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // FIR stand-in: a pure FIR_LAT delay of the accepted sample, sign-extended.
    logic [5:0] fpipe [FIR_LAT];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIR_LAT; i++) fpipe[i] <= '0;
        end else begin
            fpipe[0] <= (fir_tvalid && fir_tready) ? fir_tdata : 6'd0;
            for (int i = 1; i < FIR_LAT; i++) fpipe[i] <= fpipe[i-1];
        end
    end
    assign fir_result = {{2{fpipe[FIR_LAT-1][5]}}, fpipe[FIR_LAT-1]};

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   tready_mode = 0;
    logic pop0 = 1'b0;
    logic pop1 = 1'b0;

    logic [5:0] src0 [$];
    logic [5:0] src1 [$];
    exp_t       exp_q [$];

    int flush_cnt, flush_bad, overlap, outs_seen, acc_cnt0, acc_cnt1, first_acc;
    int cur_ch, cur_len, last_acc_cyc, min_gap, max_gap;
    int bursts_ch [$];
    int bursts_len [$];

    function automatic logic [7:0] sext(input logic [5:0] x);
        return {{2{x[5]}}, x};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want)
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
        else
            n_pass++;
    endtask

    task automatic begin_scn();
        flush_cnt = 0; flush_bad = 0; overlap = 0; outs_seen = 0;
        acc_cnt0 = 0; acc_cnt1 = 0; first_acc = -1;
        cur_ch = 0; cur_len = 0; last_acc_cyc = 0;
        min_gap = 1000000; max_gap = 0;
        bursts_ch.delete(); bursts_len.delete();
    endtask

    task automatic monitor();
        exp_t e;
        int   gap;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                e.ch   = 2'(i);
                e.data = sext(req_data[6*i +: 6]);
                e.cyc  = cyc;
                exp_q.push_back(e);
                if (i == 0) begin pop0 = 1'b1; acc_cnt0++; end
                else        begin pop1 = 1'b1; acc_cnt1++; end
                if (first_acc < 0) first_acc = cyc;
                if (cur_len > 0 && i != cur_ch) begin
                    bursts_ch.push_back(cur_ch);
                    bursts_len.push_back(cur_len);
                    gap = cyc - last_acc_cyc;
                    if (gap < min_gap) min_gap = gap;
                    if (gap > max_gap) max_gap = gap;
                    cur_len = 0;
                end
                cur_ch = i;
                cur_len++;
                last_acc_cyc = cyc;
            end
        end
        if ($countones(req_ready) > 1) overlap++;
        if (fir_tvalid && fir_tready && req_ready == '0) begin
            flush_cnt++;
            if (fir_tdata != 6'd0) flush_bad++;
        end
        if (out_valid) begin
            outs_seen++;
            chk("out_pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_ch", 32'(out_ch), 32'(e.ch));
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("out_latency", 32'(cyc - int'(e.cyc)), FIR_LAT + 1);
            end
        end
    endtask

    // One clock cycle: drive inputs, sample mid-cycle, cross the rising edge.
    task automatic step();
        logic [5:0] tmp;
        if (pop0 && src0.size() > 0) tmp = src0.pop_front();
        if (pop1 && src1.size() > 0) tmp = src1.pop_front();
        pop0 = 1'b0;
        pop1 = 1'b0;
        req_valid[0]  = (src0.size() > 0);
        req_data[5:0] = (src0.size() > 0) ? src0[0] : 6'd0;
        req_valid[1]  = (src1.size() > 0);
        req_data[11:6] = (src1.size() > 0) ? src1[0] : 6'd0;
        case (tready_mode)
            1:       fir_tready = cyc[0];
            2:       fir_tready = 1'b0;
            default: fir_tready = 1'b1;
        endcase
        @(negedge clk);
        if (!reset) monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_queues();
        src0.delete(); src1.delete(); exp_q.delete();
        pop0 = 1'b0; pop1 = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((src0.size() > 0 || src1.size() > 0 || exp_q.size() > 0 || busy) && n < 400) begin
            step();
            n++;
        end
        chk({tag, "_drained"}, 32'(n < 400), 1);
        repeat (3) step();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_fir_tvalid"}, 32'(fir_tvalid), 0);
        chk({tag, "_fir_tdata"}, 32'(fir_tdata), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_data"}, 32'(out_data), 0);
        chk({tag, "_out_ch"}, 32'(out_ch), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        int v, n;
        reset      = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        fir_tready = 1'b1;
        begin_scn();

        // Reset state
        repeat (3) step();
        chk_zero_outputs("rst");
        reset = 1'b0;
        repeat (2) step();
        chk_zero_outputs("post_rst");

        // ch0 streams 5,6,7: first grant after reset flushes 8 zeros
        begin_scn();
        src0.push_back(6'd5); src0.push_back(6'd6); src0.push_back(6'd7);
        v = cyc;
        drain("s1");
        chk("s1_flush_cnt", flush_cnt, FLUSH_LEN);
        chk("s1_flush_zero", flush_bad, 0);
        chk("s1_accepts", acc_cnt0, 3);
        chk("s1_outputs", outs_seen, 3);
        chk("s1_first_accept_delay", first_acc - v, 1 + FLUSH_LEN);

        // ch1 only: 4 samples, valid drops, then 4 more without a flush
        begin_scn();
        src1.push_back(6'd1); src1.push_back(6'd2); src1.push_back(6'd3); src1.push_back(6'h3D);
        drain("s3a");
        chk("s3a_flush_cnt", flush_cnt, FLUSH_LEN);
        chk("s3a_accepts", acc_cnt1, 4);
        begin_scn();
        src1.push_back(6'd10); src1.push_back(6'd11); src1.push_back(6'h3F); src1.push_back(6'h20);
        v = cyc;
        drain("s3b");
        chk("s3b_flush_cnt", flush_cnt, 0);
        chk("s3b_accepts", acc_cnt1, 4);
        chk("s3b_outputs", outs_seen, 4);
        chk("s3b_regrant_delay", first_acc - v, 1);

        // ch0 and ch1 both continuously valid: alternating bursts of 16
        begin_scn();
        for (int i = 0; i < 32; i++) begin
            src0.push_back(6'(i));
            src1.push_back(6'(63 - i));
        end
        drain("s2");
        if (cur_len > 0) begin
            bursts_ch.push_back(cur_ch);
            bursts_len.push_back(cur_len);
        end
        chk("s2_overlap", overlap, 0);
        chk("s2_flush_cnt", flush_cnt, 4 * FLUSH_LEN);
        chk("s2_flush_zero", flush_bad, 0);
        chk("s2_accepts0", acc_cnt0, 32);
        chk("s2_accepts1", acc_cnt1, 32);
        chk("s2_num_bursts", bursts_ch.size(), 4);
        for (int k = 0; k < bursts_ch.size() && k < 4; k++) begin
            chk("s2_burst_ch", bursts_ch[k], k % 2);
            chk("s2_burst_len", bursts_len[k], BURST);
        end
        chk("s2_min_gap", min_gap, 2 + FLUSH_LEN);
        chk("s2_max_gap", max_gap, 2 + FLUSH_LEN);

        // fir_tready toggling through flush and grant
        begin_scn();
        tready_mode = 1;
        src0.push_back(6'd9);  src0.push_back(6'h30); src0.push_back(6'd17);
        src0.push_back(6'd4);  src0.push_back(6'h3E); src0.push_back(6'd31);
        drain("s4");
        tready_mode = 0;
        chk("s4_flush_cnt", flush_cnt, FLUSH_LEN);
        chk("s4_flush_zero", flush_bad, 0);
        chk("s4_accepts", acc_cnt0, 6);
        chk("s4_outputs", outs_seen, 6);

        // Reset with three results in flight
        begin_scn();
        for (int i = 1; i <= 20; i++) src1.push_back(6'(i));
        n = 0;
        while (acc_cnt1 < 3 && n < 60) begin step(); n++; end
        chk("s5_reached_3_accepts", acc_cnt1, 3);
        chk("s5_none_out_yet", outs_seen, 0);
        reset = 1'b1;
        clear_queues();
        #1;
        chk_zero_outputs("s5_in_rst");
        repeat (3) step();
        reset = 1'b0;
        begin_scn();
        repeat (10) step();
        chk("s5_no_stale_out", outs_seen, 0);
        chk_zero_outputs("s5_after_rst");
        begin_scn();
        src1.push_back(6'd2); src1.push_back(6'h21);
        drain("s5b");
        chk("s5b_flush_cnt", flush_cnt, FLUSH_LEN);
        chk("s5b_outputs", outs_seen, 2);

`ifdef FIR_SCHED_TIMEOUT_EN
        // FIR stalls during a grant: err after TIMEOUT stalled cycles
        begin_scn();
        for (int i = 0; i < 8; i++) src0.push_back(6'(i + 1));
        n = 0;
        while (acc_cnt0 < 1 && n < 60) begin step(); n++; end
        chk("s6_first_accept", acc_cnt0, 1);
        tready_mode = 2;
        repeat (TIMEOUT - 1) step();
        chk("s6_err_before_limit", 32'(err), 0);
        chk("s6_busy_before_limit", 32'(busy), 1);
        step();
        chk("s6_err_at_limit", 32'(err), 1);
        chk("s6_busy_at_limit", 32'(busy), 0);
        tready_mode = 0;
        repeat (10) step();
        chk("s6_err_sticky", 32'(err), 1);
        reset = 1'b1;
        clear_queues();
        #1;
        chk("s6_err_cleared", 32'(err), 0);
        repeat (2) step();
        reset = 1'b0;
        repeat (2) step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
